// File: rtl/pwm_pkg.sv
// Shared mode constants and the duty clip helper for the half-bridge PWM channel.
package pwm_pkg;

    localparam logic PWM_EDGE   = 1'b0;
    localparam logic PWM_CENTER = 1'b1;

    // Truncate value to width bits, then clamp into [lo, hi].
    function automatic int unsigned pwm_clip(
        input int unsigned width,
        input int unsigned value,
        input int unsigned lo,
        input int unsigned hi
    );
        int unsigned v;
        v = value & ((32'd1 << width) - 32'd1);
        if (v > hi) begin
            v = hi;
        end else begin
            v = v;
        end
        if (v < lo) begin
            v = lo;
        end else begin
            v = v;
        end
        return v;
    endfunction

endpackage

// File: rtl/pwm_deadtime.sv
// Deadtime insertion between the single-ended PWM and the complementary gate pair;
// also holds both gates off while disabled or in reset.
module pwm_deadtime #(
    parameter int unsigned DT_WIDTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                pwmin,
    input  logic [DT_WIDTH-1:0] deadtime,
    output logic [1:0]          pwmout
);
    localparam logic [DT_WIDTH-1:0] DC_ZERO = {DT_WIDTH{1'b0}};
    localparam logic [DT_WIDTH-1:0] DC_ONE  = DT_WIDTH'(1);

    logic                state_r;
    logic                state_nxt;
    logic [DT_WIDTH-1:0] dc_r;
    logic [DT_WIDTH-1:0] dc_nxt;
    logic [1:0]          pwmout_r;

    // Next state: a toggle (even mid-interval) restarts the dead interval
    always_comb begin
        state_nxt = state_r;
        dc_nxt    = dc_r;
        if (!enable) begin
            state_nxt = 1'b0;
            dc_nxt    = deadtime;
        end else if (pwmin != state_r) begin
            state_nxt = pwmin;
            dc_nxt    = deadtime;
        end else if (dc_r != DC_ZERO) begin
            dc_nxt = dc_r - DC_ONE;
        end else begin
            dc_nxt = dc_r;
        end
    end

    // Gates are registered from the next state so a pwmin change reaches the pins one clk later
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= 1'b0;
            dc_r     <= deadtime;
            pwmout_r <= 2'b00;
        end else begin
            state_r <= state_nxt;
            dc_r    <= dc_nxt;
            if (enable && (dc_nxt == DC_ZERO)) begin
                pwmout_r <= {~state_nxt, state_nxt};
            end else begin
                pwmout_r <= 2'b00;
            end
        end
    end

    assign pwmout = pwmout_r;

endmodule

// File: rtl/pwm_halfbridge.sv
// Half-bridge PWM channel: period counter, shadowed clipped duty, comparator and
// cycle-by-cycle current limit, driving the deadtime stage.
module pwm_halfbridge
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DT_WIDTH = 4,
    parameter int unsigned PWM_MIN  = 3,
    parameter int unsigned PWM_MAX  = (2 ** WIDTH) - 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pwmcntce,
    input  logic                pwmldce,
    input  logic [WIDTH-1:0]    wrtdata,
    input  logic [DT_WIDTH-1:0] deadtime,
    input  logic                centermode,
    input  logic                invertpwm,
    input  logic                enablepwm,
    input  logic                currentlimit,
    output logic [1:0]          pwmout,
    output logic                cyclestart,
    output logic                ilimflag
);
    localparam logic [WIDTH-1:0] CNT_ZERO   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_MAX    = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE    = WIDTH'(1);
    localparam logic [WIDTH-1:0] DUTY_RST   = WIDTH'(2 ** (WIDTH - 1));
    localparam logic [WIDTH-1:0] SHADOW_RST = WIDTH'(pwm_clip(WIDTH, 2 ** (WIDTH - 1), PWM_MIN, PWM_MAX));

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_nxt;
    logic             dir_up_r;
    logic             dir_up_nxt;
    logic             dir_eff;
    logic             mode_r;
    logic             start_evt;
    logic [WIDTH-1:0] duty_r;
    logic [WIDTH-1:0] shadow_r;
    logic [WIDTH-1:0] shadow_nxt;
    logic [WIDTH-1:0] clipped;
    logic             ilim_r;
    logic             raw_r;
    logic             cyclestart_r;
    logic             pwmin;

    assign clipped    = WIDTH'(pwm_clip(WIDTH, 32'(duty_r), PWM_MIN, PWM_MAX));
    assign shadow_nxt = start_evt ? clipped : shadow_r;
    assign pwmin      = raw_r ^ invertpwm;

    // Counter step and start detection; a mode change restarts the sweep upwards
    always_comb begin
        dir_eff    = (centermode != mode_r) ? 1'b1 : dir_up_r;
        count_nxt  = count_r;
        dir_up_nxt = dir_eff;
        start_evt  = pwmcntce & ((centermode == PWM_CENTER) ? (count_r == CNT_ZERO)
                                                            : (count_r == CNT_MAX));
        if (!pwmcntce) begin
            count_nxt = count_r;
        end else if (centermode == PWM_EDGE) begin
            count_nxt  = count_r + CNT_ONE;
            dir_up_nxt = 1'b1;
        end else if (dir_eff) begin
            if (count_r == CNT_MAX) begin
                count_nxt  = count_r - CNT_ONE;
                dir_up_nxt = 1'b0;
            end else begin
                count_nxt = count_r + CNT_ONE;
            end
        end else begin
            if (count_r == CNT_ZERO) begin
                count_nxt  = CNT_ONE;
                dir_up_nxt = 1'b1;
            end else begin
                count_nxt = count_r - CNT_ONE;
            end
        end
    end

    // Period state, duty/shadow registers, current-limit latch and comparator
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r      <= CNT_ZERO;
            dir_up_r     <= 1'b1;
            mode_r       <= PWM_EDGE;
            duty_r       <= DUTY_RST;
            shadow_r     <= SHADOW_RST;
            ilim_r       <= 1'b0;
            raw_r        <= 1'b0;
            cyclestart_r <= 1'b0;
        end else begin
            count_r      <= count_nxt;
            dir_up_r     <= dir_up_nxt;
            mode_r       <= centermode;
            shadow_r     <= shadow_nxt;
            cyclestart_r <= start_evt;
            if (pwmldce) begin
                duty_r <= wrtdata;
            end else begin
                duty_r <= duty_r;
            end
            // A trip on the start edge itself survives the period clear
            if (currentlimit) begin
                ilim_r <= 1'b1;
            end else if (start_evt) begin
                ilim_r <= 1'b0;
            end else begin
                ilim_r <= ilim_r;
            end
            raw_r <= (count_r < shadow_nxt) && !(ilim_r && !start_evt);
        end
    end

    pwm_deadtime #(
        .DT_WIDTH (DT_WIDTH)
    ) u_deadtime (
        .clk      (clk),
        .reset    (reset),
        .enable   (enablepwm),
        .pwmin    (pwmin),
        .deadtime (deadtime),
        .pwmout   (pwmout)
    );

    assign cyclestart = cyclestart_r;
    assign ilimflag   = ilim_r;

endmodule

// File: tb/tb_pwm_halfbridge.sv
// Directed self-checking bench for pwm_halfbridge with WIDTH=8, DT_WIDTH=4 and default clips.
module tb_pwm_halfbridge;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pwmcntce = 1'b1;
    logic       pwmldce = 1'b0;
    logic [7:0] wrtdata = 8'd0;
    logic [3:0] deadtime = 4'd0;
    logic       centermode = 1'b0;
    logic       invertpwm = 1'b0;
    logic       enablepwm = 1'b1;
    logic       currentlimit = 1'b0;
    logic [1:0] pwmout;
    logic       cyclestart;
    logic       ilimflag;

    int total = 0;
    int bad = 0;

    logic [1:0] win_pw [0:520];
    logic       win_cs [0:520];

    pwm_halfbridge #(
        .WIDTH    (8),
        .DT_WIDTH (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pwmcntce     (pwmcntce),
        .pwmldce      (pwmldce),
        .wrtdata      (wrtdata),
        .deadtime     (deadtime),
        .centermode   (centermode),
        .invertpwm    (invertpwm),
        .enablepwm    (enablepwm),
        .currentlimit (currentlimit),
        .pwmout       (pwmout),
        .cyclestart   (cyclestart),
        .ilimflag     (ilimflag)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_duty(input logic [7:0] v);
        wrtdata = v;
        pwmldce = 1'b1;
        step();
        pwmldce = 1'b0;
    endtask

    task automatic wait_cs(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            step();
            if (cyclestart === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Skip to a clean period (two starts), then record n clks after the start pulse
    task automatic measure(input int n, output bit ok);
        bit ok1;
        bit ok2;
        wait_cs(ok1);
        wait_cs(ok2);
        ok = ok1 & ok2;
        for (int j = 1; j <= n; j++) begin
            step();
            win_pw[j] = pwmout;
            win_cs[j] = cyclestart;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step();
        total++; if (pwmout !== 2'b00) begin bad++; $display("FAIL reset_pwmout got=%b want=00", pwmout); end
        total++; if (cyclestart !== 1'b0) begin bad++; $display("FAIL reset_cyclestart got=%b want=0", cyclestart); end
        total++; if (ilimflag !== 1'b0) begin bad++; $display("FAIL reset_ilimflag got=%b want=0", ilimflag); end
        reset = 1'b0;
    endtask

    task automatic test_edge_duty();
        int duties [3];
        int exp_hi [3];
        bit ok;
        int hi;
        int lo;
        int csn;
        duties = '{128, 0, 255};
        exp_hi = '{128, 3, 251};
        deadtime = 4'd0;
        centermode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            write_duty(8'(duties[i]));
            measure(256, ok);
            total++; if (!ok) begin bad++; $display("FAIL edge_timeout duty=%0d got=no cyclestart want=cyclestart", duties[i]); end
            hi = 0; lo = 0; csn = 0;
            for (int j = 1; j <= 256; j++) begin
                hi += int'(win_pw[j][0]);
                lo += int'(win_pw[j][1]);
                csn += int'(win_cs[j]);
            end
            total++; if (hi != exp_hi[i]) begin bad++; $display("FAIL edge_high duty=%0d got=%0d want=%0d", duties[i], hi, exp_hi[i]); end
            total++; if (lo != 256 - exp_hi[i]) begin bad++; $display("FAIL edge_low duty=%0d got=%0d want=%0d", duties[i], lo, 256 - exp_hi[i]); end
            total++; if (csn != 1 || win_cs[256] !== 1'b1) begin bad++; $display("FAIL edge_period duty=%0d got=%0d pulses last=%b want=1 pulse at 256", duties[i], csn, win_cs[256]); end
        end
    endtask

    task automatic test_center();
        bit ok;
        int hi;
        int csn;
        centermode = 1'b1;
        write_duty(8'd64);
        measure(510, ok);
        total++; if (!ok) begin bad++; $display("FAIL center_timeout got=no cyclestart want=cyclestart"); end
        hi = 0; csn = 0;
        for (int j = 1; j <= 510; j++) begin
            hi += int'(win_pw[j][0]);
            csn += int'(win_cs[j]);
        end
        total++; if (hi != 127) begin bad++; $display("FAIL center_high got=%0d want=127", hi); end
        total++; if (csn != 1 || win_cs[510] !== 1'b1) begin bad++; $display("FAIL center_period got=%0d last=%b want=1 pulse at 510", csn, win_cs[510]); end
        total++; if (win_pw[1][0] !== 1'b1 || win_pw[64][0] !== 1'b1 || win_pw[65][0] !== 1'b0) begin
            bad++; $display("FAIL center_rise_side got=%b%b%b want=110", win_pw[1][0], win_pw[64][0], win_pw[65][0]);
        end
        total++; if (win_pw[447][0] !== 1'b0 || win_pw[448][0] !== 1'b1) begin
            bad++; $display("FAIL center_fall_side got=%b%b want=01", win_pw[447][0], win_pw[448][0]);
        end
        centermode = 1'b0;
    endtask

    task automatic test_current_limit();
        bit ok1;
        bit ok2;
        int stray;
        deadtime = 4'd0;
        write_duty(8'd100);
        wait_cs(ok1);
        wait_cs(ok2);
        total++; if (!(ok1 && ok2)) begin bad++; $display("FAIL ilim_timeout got=no cyclestart want=cyclestart"); end
        stray = 0;
        for (int j = 1; j <= 258; j++) begin
            step();
            if (j == 21) begin
                currentlimit = 1'b0;
                total++; if (ilimflag !== 1'b1) begin bad++; $display("FAIL ilim_flag_set got=%b want=1", ilimflag); end
            end
            if (j == 20) currentlimit = 1'b1;
            if (j == 22) begin
                total++; if (pwmout[0] !== 1'b1) begin bad++; $display("FAIL ilim_before_cut got=%b want=1", pwmout[0]); end
            end
            if (j >= 23 && j <= 257 && pwmout[0] !== 1'b0) stray++;
            if (j == 255) begin
                total++; if (ilimflag !== 1'b1) begin bad++; $display("FAIL ilim_flag_held got=%b want=1", ilimflag); end
            end
            if (j == 256) begin
                total++; if (cyclestart !== 1'b1 || ilimflag !== 1'b0) begin
                    bad++; $display("FAIL ilim_flag_clear got=cs%b flag%b want=cs1 flag0", cyclestart, ilimflag);
                end
            end
            if (j == 258) begin
                total++; if (pwmout[0] !== 1'b1) begin bad++; $display("FAIL ilim_next_period got=%b want=1", pwmout[0]); end
            end
        end
        total++; if (stray != 0) begin bad++; $display("FAIL ilim_cut got=%0d high clks want=0", stray); end
    endtask

    task automatic test_deadtime();
        bit ok;
        int hi;
        int lo;
        int zeros;
        int shoot;
        deadtime = 4'd3;
        write_duty(8'd128);
        measure(256, ok);
        hi = 0; lo = 0; zeros = 0; shoot = 0;
        for (int j = 1; j <= 256; j++) begin
            hi += int'(win_pw[j] == 2'b01);
            lo += int'(win_pw[j] == 2'b10);
            zeros += int'(win_pw[j] == 2'b00);
            shoot += int'(win_pw[j] == 2'b11);
        end
        total++; if (!ok) begin bad++; $display("FAIL dt3_timeout got=no cyclestart want=cyclestart"); end
        total++; if (zeros != 6 || shoot != 0) begin bad++; $display("FAIL dt3_dead got=%0d zeros %0d overlap want=6 zeros 0 overlap", zeros, shoot); end
        total++; if (hi != 125 || lo != 125) begin bad++; $display("FAIL dt3_split got=hi%0d lo%0d want=hi125 lo125", hi, lo); end
        total++; if (win_pw[4] !== 2'b00 || win_pw[5] !== 2'b01 || win_pw[132] !== 2'b00 || win_pw[133] !== 2'b10) begin
            bad++; $display("FAIL dt3_edges got=%b %b %b %b want=00 01 00 10", win_pw[4], win_pw[5], win_pw[132], win_pw[133]);
        end
        deadtime = 4'd4;
        write_duty(8'd0);
        measure(256, ok);
        hi = 0; lo = 0; zeros = 0;
        for (int j = 1; j <= 256; j++) begin
            hi += int'(win_pw[j][0]);
            lo += int'(win_pw[j] == 2'b10);
            zeros += int'(win_pw[j] == 2'b00);
        end
        total++; if (!ok) begin bad++; $display("FAIL dt4_timeout got=no cyclestart want=cyclestart"); end
        total++; if (hi != 0) begin bad++; $display("FAIL dt4_short_pulse got=%0d high clks want=0", hi); end
        total++; if (zeros != 7 || lo != 249 || win_pw[9] !== 2'b10) begin
            bad++; $display("FAIL dt4_dead got=zeros%0d lo%0d pw9=%b want=zeros7 lo249 pw9=10", zeros, lo, win_pw[9]);
        end
    endtask

    task automatic test_write_disable_reset();
        bit ok1;
        bit ok2;
        int stray;
        int zeros;
        bit seen;
        int cs_at;
        int hi;
        deadtime = 4'd3;
        write_duty(8'd128);
        wait_cs(ok1);
        wait_cs(ok2);
        total++; if (!(ok1 && ok2)) begin bad++; $display("FAIL seq_timeout got=no cyclestart want=cyclestart"); end
        stray = 0;
        for (int j = 1; j <= 480; j++) begin
            step();
            if (j == 11) pwmldce = 1'b0;
            if (j == 10) begin wrtdata = 8'd200; pwmldce = 1'b1; end
            if (j == 160) begin
                total++; if (pwmout !== 2'b10) begin bad++; $display("FAIL seq_old_duty got=%b want=10", pwmout); end
            end
            if (j == 256) begin
                total++; if (cyclestart !== 1'b1) begin bad++; $display("FAIL seq_period got=%b want=1", cyclestart); end
            end
            if (j == 416) begin
                total++; if (pwmout !== 2'b01) begin bad++; $display("FAIL seq_new_duty got=%b want=01", pwmout); end
                enablepwm = 1'b0;
            end
            if (j == 417) begin
                total++; if (pwmout !== 2'b00) begin bad++; $display("FAIL seq_disable got=%b want=00", pwmout); end
            end
            if (j > 417 && pwmout !== 2'b00) stray++;
            if (j == 476) pwmcntce = 1'b0;
        end
        total++; if (stray != 0) begin bad++; $display("FAIL seq_disabled_hold got=%0d active clks want=0", stray); end
        enablepwm = 1'b1;
        zeros = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (pwmout === 2'b00) zeros++;
            else seen = 1'b1;
            if (!seen) step();
        end
        total++; if (zeros != 3 || pwmout !== 2'b10) begin bad++; $display("FAIL seq_reenable got=%0d dead then %b want=3 dead then 10", zeros, pwmout); end
        pwmcntce = 1'b1;
        for (int i = 0; i < 5; i++) step();
        reset = 1'b1;
        step();
        total++; if (pwmout !== 2'b00 || cyclestart !== 1'b0 || ilimflag !== 1'b0) begin
            bad++; $display("FAIL seq_reset_outputs got=%b/%b/%b want=00/0/0", pwmout, cyclestart, ilimflag);
        end
        reset = 1'b0;
        cs_at = 0;
        for (int j = 1; j <= 600 && cs_at == 0; j++) begin
            step();
            if (cyclestart === 1'b1) cs_at = j;
        end
        total++; if (cs_at != 256) begin bad++; $display("FAIL seq_reset_count got=%0d want=256", cs_at); end
        measure(256, ok1);
        hi = 0;
        for (int j = 1; j <= 256; j++) hi += int'(win_pw[j] == 2'b01);
        total++; if (!ok1 || hi != 125) begin bad++; $display("FAIL seq_reset_duty got=%0d ok=%b want=125 ok=1", hi, ok1); end
    endtask

    initial begin
        test_reset();
        test_edge_duty();
        test_center();
        test_current_limit();
        test_deadtime();
        test_write_disable_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
